// File: rtl/iecdrv_mixmem_if.sv
// Bus interface for iecdrv_mixmem: word-wide port A, narrow port B, dirty flag.
// master drives requests (host / GCR head), slave is the memory.
interface iecdrv_mixmem_if #(
  parameter int ADDRWIDTH = 13,
  parameter int DATAWIDTH = 8,
  parameter int NARROW    = 1
);
  localparam int SUBW = $clog2(DATAWIDTH / NARROW);

  logic                      a_req;
  logic                      a_we;
  logic [ADDRWIDTH-1:0]      a_addr;
  logic [DATAWIDTH-1:0]      a_din;
  logic                      a_ack;
  logic [DATAWIDTH-1:0]      a_dout;

  logic                      b_req;
  logic                      b_we;
  logic [ADDRWIDTH+SUBW-1:0] b_addr;
  logic [NARROW-1:0]         b_din;
  logic                      b_ack;
  logic [NARROW-1:0]         b_dout;

  logic                      dirty;
  logic                      dirty_clr;

  modport master (
    output a_req, a_we, a_addr, a_din,
    input  a_ack, a_dout,
    output b_req, b_we, b_addr, b_din,
    input  b_ack, b_dout,
    input  dirty,
    output dirty_clr
  );

  modport slave (
    input  a_req, a_we, a_addr, a_din,
    output a_ack, a_dout,
    input  b_req, b_we, b_addr, b_din,
    output b_ack, b_dout,
    output dirty,
    input  dirty_clr
  );
endinterface

// File: rtl/iecdrv_mixmem.sv
// Mixed-width shared RAM: word port A, sub-word port B via read-modify-write.
// Optional write-tracking flag enabled by defining IECDRV_MIXMEM_DIRTY_EN.
//
// state  | meaning
// IDLE   | waiting for a request; round-robin grant on a tie
// ACCESS | latched address at RAM; A write commits here, others read
// RESP   | read data presented with ack
// MERGE  | B write: read word written back with one slice replaced
module iecdrv_mixmem #(
  parameter int ADDRWIDTH = 13,
  parameter int DATAWIDTH = 8,
  parameter int NARROW    = 1
) (
  input logic            clk,
  input logic            reset_n,
  iecdrv_mixmem_if.slave bus
);
  localparam int SUBW  = $clog2(DATAWIDTH / NARROW);
  localparam int SW    = (SUBW > 0) ? SUBW : 1;
  localparam int BAW   = ADDRWIDTH + SUBW;
  localparam int DEPTH = 2 ** ADDRWIDTH;

  if (((NARROW & (NARROW - 1)) != 0) || ((DATAWIDTH % NARROW) != 0)) begin : g_bad_narrow
    $error("iecdrv_mixmem: NARROW must be a power of two dividing DATAWIDTH");
  end

  typedef enum logic [1:0] {IDLE, ACCESS, RESP, MERGE} state_t;

  state_t               state;
  logic                 last_b;
  logic                 sel_b;
  logic                 lat_we;
  logic [ADDRWIDTH-1:0] lat_addr;
  logic [SW-1:0]        lat_slice;
  logic [DATAWIDTH-1:0] lat_din;
  logic [NARROW-1:0]    lat_bdin;
  logic [DATAWIDTH-1:0] rd_word;
  logic                 a_ack_q;
  logic                 b_ack_q;
  logic [DATAWIDTH-1:0] a_dout_q;
  logic [NARROW-1:0]    b_dout_q;

  logic [DATAWIDTH-1:0] mem [DEPTH];
  logic [DATAWIDTH-1:0] ram_rd;
  logic [DATAWIDTH-1:0] merged;
  logic [DATAWIDTH-1:0] ram_wdata;
  logic                 ram_we;
  logic [ADDRWIDTH-1:0] b_word_in;
  logic [SW-1:0]        b_slice_in;

  assign b_word_in = bus.b_addr[BAW-1:SUBW];

  if (SUBW > 0) begin : g_slice
    assign b_slice_in = bus.b_addr[SW-1:0];
  end else begin : g_noslice
    assign b_slice_in = '0;
  end

  assign ram_rd = mem[lat_addr];

  always_comb begin
    merged = rd_word;
    merged[int'(lat_slice) * NARROW +: NARROW] = lat_bdin;
  end

  // State is forced to IDLE asynchronously, so no write can fire during reset.
  assign ram_we    = ((state == ACCESS) && !sel_b && lat_we) || (state == MERGE);
  assign ram_wdata = (state == MERGE) ? merged : lat_din;

  always_ff @(posedge clk) begin
    if (ram_we) mem[lat_addr] <= ram_wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      last_b    <= 1'b1;
      sel_b     <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_slice <= '0;
      lat_din   <= '0;
      lat_bdin  <= '0;
      rd_word   <= '0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      a_dout_q  <= '0;
      b_dout_q  <= '0;
    end else begin
      a_ack_q <= 1'b0;
      b_ack_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.a_req && (!bus.b_req || last_b)) begin
            sel_b    <= 1'b0;
            last_b   <= 1'b0;
            lat_we   <= bus.a_we;
            lat_addr <= bus.a_addr;
            lat_din  <= bus.a_din;
            a_ack_q  <= bus.a_we;
            state    <= ACCESS;
          end else if (bus.b_req) begin
            sel_b     <= 1'b1;
            last_b    <= 1'b1;
            lat_we    <= bus.b_we;
            lat_addr  <= b_word_in;
            lat_slice <= b_slice_in;
            lat_bdin  <= bus.b_din;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (!sel_b && lat_we) begin
            state <= IDLE;
          end else if (!sel_b) begin
            a_dout_q <= ram_rd;
            a_ack_q  <= 1'b1;
            state    <= RESP;
          end else if (!lat_we) begin
            b_dout_q <= ram_rd[int'(lat_slice) * NARROW +: NARROW];
            b_ack_q  <= 1'b1;
            state    <= RESP;
          end else begin
            rd_word <= ram_rd;
            b_ack_q <= 1'b1;
            state   <= MERGE;
          end
        end
        RESP:    state <= IDLE;
        MERGE:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.a_ack  = a_ack_q;
  assign bus.b_ack  = b_ack_q;
  assign bus.a_dout = a_dout_q;
  assign bus.b_dout = b_dout_q;

`ifdef IECDRV_MIXMEM_DIRTY_EN
  logic dirty_q;

  // A completing write outranks a simultaneous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          dirty_q <= 1'b0;
    else if (ram_we)       dirty_q <= 1'b1;
    else if (bus.dirty_clr) dirty_q <= 1'b0;
  end

  assign bus.dirty = dirty_q;
`else
  logic unused_dirty_clr;

  assign unused_dirty_clr = bus.dirty_clr;
  assign bus.dirty        = 1'b0;
`endif
endmodule

// File: doc/iecdrv_mixmem.md
Name: iecdrv_mixmem

Overview:
- Single-clock, mixed-width shared memory for the drive core.
- Port A is a word-wide controller port, for CPU or host image load.
- Port B is a narrow port for the GCR bit-stream head, with sub-word read and write.
- One single-port synchronous RAM array sits behind an arbitrating FSM. Narrow writes are done as hardware read-modify-write, so no mixed-width RAM inference is needed.

Parameters:
- ADDRWIDTH, 13, word address width; depth = 2**ADDRWIDTH words.
- DATAWIDTH, 8, port A word width.
- NARROW, 1, port B width. Must be a power of two and divide DATAWIDTH.
- SUBW (derived, not overridable): log2(DATAWIDTH/NARROW). When NARROW = DATAWIDTH, SUBW = 0 and port B acts as a second word port.

Ports:
- clk  in  1  single clock; all logic on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- a_req  in  1  port A request; held until a_ack.
- a_we  in  1  1 = write, 0 = read; sampled at grant.
- a_addr  in  ADDRWIDTH  word address.
- a_din  in  DATAWIDTH  write data.
- a_ack  out  1  one-cycle completion pulse.
- a_dout  out  DATAWIDTH  read data; valid with a_ack on reads.
- b_req  in  1  port B request; held until b_ack.
- b_we  in  1  1 = write, 0 = read.
- b_addr  in  ADDRWIDTH+SUBW  {word address, slice index}; slice 0 = bits [NARROW-1:0].
- b_din  in  NARROW  write data.
- b_ack  out  1  one-cycle completion pulse.
- b_dout  out  NARROW  read slice; valid with b_ack on reads.
- dirty  out  1  a write has completed since the last clear (optional feature).
- dirty_clr  in  1  clears dirty.

Behaviour:
- Reset (asynchronous, reset_n = 0):
  - FSM goes to IDLE; a_ack, b_ack, a_dout, b_dout and dirty are all 0.
  - Last-grant pointer points to B, so A wins the first tie.
  - RAM contents are not cleared.
  - An operation in progress is aborted. No RAM write occurs on any edge while reset_n = 0.
- FSM states: IDLE, ACCESS, RESP, MERGE.
- IDLE, grant:
  - Only one of a_req/b_req high: grant that port.
  - Both high: grant the port not served last (round-robin).
  - On grant, latch we, addr and din, then go to ACCESS.
  - Inputs are ignored after the grant edge, until ack.
- ACCESS (grant + 1):
  - Latched word address is driven to the RAM.
  - A write: RAM written with din; a_ack = 1 this cycle; next state IDLE.
  - A read, or any B op: RAM read issued. Next state is RESP for reads, MERGE for B writes.
- RESP (grant + 2):
  - A read: a_dout = RAM word, a_ack = 1.
  - B read: b_dout = word[slice*NARROW +: NARROW], b_ack = 1.
  - Next state IDLE.
- MERGE (grant + 2):
  - Write back the read word with only the addressed slice replaced by b_din. Other bits are unchanged.
  - b_ack = 1; next state IDLE.
- Latency and throughput:
  - A write: ack 1 cycle after grant.
  - Reads and B write: ack 2 cycles after grant.
  - After every ack, one IDLE cycle follows.
  - A req still high in that IDLE cycle is treated as a new request.
- a_dout and b_dout hold their last value between reads. Writes do not update them.
- Only one operation is ever in flight, so no read/write hazards are possible. Sequential ops see prior writes.
- Address wrap: none. The full address range is valid.

Optional Feature:
- Macro: IECDRV_MIXMEM_DIRTY_EN.
- Defined:
  - dirty is set in the cycle after any write ack, from port A or B.
  - dirty_clr = 1 clears dirty on the next edge.
  - If set and clear fall on the same edge, set wins and dirty stays 1.
- Undefined: dirty is constant 0 and dirty_clr is ignored. Ports remain present.

Test Plan:
All scenarios use ADDRWIDTH=4, DATAWIDTH=8, NARROW=1.
1. A write 0xA5 to word 3 -> a_ack exactly 1 cycle after grant. Then A read of word 3 -> a_dout = 0xA5 with a_ack 2 cycles after grant.
2. B write 0 to b_addr {3, 5}, then A read of word 3 -> 0x85. B read of {3,7} -> b_dout = 1; B read of {3,6} -> 0.
3. a_req and b_req rise together, both held, for 4 ops -> grants are A, B, A, B. Each ack is single-cycle, and an IDLE cycle separates consecutive ops.
4. Assert reset_n = 0 in the MERGE-preceding ACCESS cycle of a B write to {2,0} (word 2 = 0x00) -> no b_ack; word 2 still reads 0x00; all outputs are 0 during reset.
5. NARROW=4 build: A write 0x3C to word 1, then B write 0xF to {1,1} -> A read gives 0xFC. B read of {1,0} -> 0xC.
6. With IECDRV_MIXMEM_DIRTY_EN: dirty = 0 after reset, 1 after one A write. dirty_clr pulsed on the same edge as a new set -> dirty stays 1. A lone dirty_clr -> 0. Without the macro: dirty stays 0 throughout.
